twf_round_sat: RTL and testbench
================================

Name: twf_round_sat

Overview:
- Stage directly downstream of the 16-lane twiddle multiplier.
- Takes the four 16-lane full-precision complex products (<10.13>, 23 bit): R/Q of the add path and R/Q of the sub path.
- Rounds each product back to <7.6> and saturates it to 13 bit.
- Registers the result and tracks 16-lane blocks within a 512-point frame, so the next butterfly stage receives aligned valid, frame-start and frame-done markers plus a per-frame saturation status.

Parameters:
- DIN_WIDTH, 23, product width <10.13>.
- DOUT_WIDTH, 13, output width <7.6>.
- SHIFT, 7, fractional bits dropped (twiddle fraction bits).
- DEPTH, 16, lanes per block.
- FRAME_BLKS, 32, blocks per frame (512/DEPTH).
- CNT_WIDTH, 5, width of the block counter, equal to clog2(FRAME_BLKS).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- din_valid  input  1  products on din_* are valid this cycle (multiplier en delayed one cycle).
- din_R_add, din_Q_add, din_R_sub, din_Q_sub  input  signed DIN_WIDTH x DEPTH  multiplier products.
- dout_R_add, dout_Q_add, dout_R_sub, dout_Q_sub  output  signed DOUT_WIDTH x DEPTH  rounded and saturated samples.
- dout_valid  output  1  dout_* valid.
- frame_start  output  1  with dout_valid, first block of a frame.
- frame_done  output  1  with dout_valid, last block of a frame.
- blk_idx  output  CNT_WIDTH  block index of the current dout.
- sat_flag  output  1  sticky; any lane saturated in the current frame.
- sat_cnt  output  9  number of saturated lane-values in the current frame, saturating at 511.

Behaviour:
- Reset: clk is the clock; rst_n is asynchronous and active-low. All dout_* = 0, dout_valid = 0, frame_start = 0, frame_done = 0, blk_idx = 0, sat_flag = 0, sat_cnt = 0, internal block counter = 0, FSM = IDLE.
- Latency: one cycle. din_valid at edge N gives dout_valid and results at edge N+1.
- No backpressure.
- When din_valid = 0: dout_valid = 0; dout_*, blk_idx, sat_flag and sat_cnt hold their values; frame_start and frame_done are 0.
- Per lane, per component (64 values per block):
  - Compute t = din + 2^(SHIFT-1) in DIN_WIDTH+1 bits (half-up rounding).
  - Arithmetic shift right by SHIFT.
  - If the result is greater than 2^(DOUT_WIDTH-1)-1 (4095), output 4095.
  - If the result is less than -2^(DOUT_WIDTH-1) (-4096), output -4096.
  - Otherwise output the low DOUT_WIDTH bits.
  - A value is "saturated" if either clamp applied.
- FSM states IDLE and RUN:
  - IDLE + din_valid: emit block 0 with frame_start = 1, counter becomes 1, go to RUN.
  - RUN + din_valid: emit block with blk_idx = counter. If counter = FRAME_BLKS-1, assert frame_done, set counter to 0, go to IDLE; otherwise increment counter.
  - Gaps in din_valid pause the counter and do not end the frame.
- Saturation statistics:
  - On a frame_start block, sat_flag and sat_cnt are overwritten with that block's values. They are not accumulated onto the old frame.
  - On other blocks, sat_flag ORs in the block's saturations, and sat_cnt adds that block's saturated count (0..64) with a clamp at 511.
  - sat_flag and sat_cnt are updated with a registered timing identical to dout.
- Single-block frame (FRAME_BLKS = 1): frame_start and frame_done assert together; FSM stays in IDLE.
- Reset mid-frame: everything returns to reset values. The next valid block is frame_start with blk_idx 0.

Optional Feature:
- Macro TWF_RND_CONV_EN.
- Defined: convergent rounding (round half to even). When the dropped bits equal exactly 2^(SHIFT-1), the result rounds to the even integer; otherwise it is nearest-value rounding as in the default mode. Saturation and statistics are unchanged.
- Undefined: half-up rounding as specified in Behaviour.

Test Plan:
- Unity and half-up rounding, all lanes, one block:
  - din = 8192 -> dout 64.
  - din = 8256 -> 65 (64 with TWF_RND_CONV_EN).
  - din = 8384 -> 66 in both modes.
  - din = -8384 -> -65 (-66 with TWF_RND_CONV_EN).
  - dout_valid one cycle after din_valid.
- Saturation, one block:
  - Lane 0 R_add = 524288 -> 4095; lane 1 Q_sub = -524416 -> -4096; all other values 0.
  - Expect sat_flag = 1, sat_cnt = 2.
- Full frame: 32 valid blocks with 3-cycle gaps after blocks 5 and 20.
  - frame_start only on block 0, frame_done only on block 31.
  - blk_idx counts 0..31 and holds during gaps.
  - dout_valid low during gaps.
- Back-to-back frames: block 0 of frame 2 arrives the cycle after frame 1's block 31.
  - frame_start asserts.
  - sat_cnt restarts from that block's count: a frame-1 count of 5 followed by a clean block gives 0.
- Reset during block 12, then 1 valid block: all outputs are 0 during reset; the next block has frame_start = 1, blk_idx = 0.
- Saturation counter clamp: 9 blocks with all 64 values saturated -> sat_cnt 64, 128, …, 448, then 511 and held.

Source files
------------

// File: rtl/twf_round_sat.sv
// Rounds 16-lane <10.13> twiddle products to saturated <7.6>, registers them and tracks
// blocks within a frame. Define TWF_RND_CONV_EN for round-half-to-even instead of half-up.
module twf_round_sat #(
    parameter int unsigned DIN_WIDTH  = 23,
    parameter int unsigned DOUT_WIDTH = 13,
    parameter int unsigned SHIFT      = 7,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned FRAME_BLKS = 32,
    parameter int unsigned CNT_WIDTH  = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         din_valid,
    input  logic signed [DIN_WIDTH-1:0]  din_R_add [DEPTH],
    input  logic signed [DIN_WIDTH-1:0]  din_Q_add [DEPTH],
    input  logic signed [DIN_WIDTH-1:0]  din_R_sub [DEPTH],
    input  logic signed [DIN_WIDTH-1:0]  din_Q_sub [DEPTH],
    output logic signed [DOUT_WIDTH-1:0] dout_R_add [DEPTH],
    output logic signed [DOUT_WIDTH-1:0] dout_Q_add [DEPTH],
    output logic signed [DOUT_WIDTH-1:0] dout_R_sub [DEPTH],
    output logic signed [DOUT_WIDTH-1:0] dout_Q_sub [DEPTH],
    output logic                         dout_valid,
    output logic                         frame_start,
    output logic                         frame_done,
    output logic [CNT_WIDTH-1:0]         blk_idx,
    output logic                         sat_flag,
    output logic [8:0]                   sat_cnt
);
    localparam int unsigned QW   = DIN_WIDTH - SHIFT + 1;
    localparam int unsigned NVAL = 4 * DEPTH;
    localparam int unsigned BCW  = $clog2(NVAL + 1);
    localparam int unsigned SCW  = 9;
    localparam int SMAX_I = (2 ** (DOUT_WIDTH - 1)) - 1;
    localparam logic signed [QW-1:0] SMAX = QW'(SMAX_I);
    localparam logic signed [QW-1:0] SMIN = QW'(-SMAX_I - 1);

    typedef enum logic {IDLE, RUN} state_e;

    // Returns {saturated, value}; rounding increment is derived from the dropped fraction.
    function automatic logic [DOUT_WIDTH:0] rnd_sat(input logic signed [DIN_WIDTH-1:0] x);
        logic signed [QW-1:0] fl;
        logic signed [QW-1:0] q;
        logic                 inc;
        fl = {x[DIN_WIDTH-1], x[DIN_WIDTH-1:SHIFT]};
`ifdef TWF_RND_CONV_EN
        inc = x[SHIFT-1] & ((|x[SHIFT-2:0]) | fl[0]);
`else
        inc = x[SHIFT-1];
`endif
        q = fl + $signed({{(QW-1){1'b0}}, inc});
        if (q > SMAX) begin
            rnd_sat = {1'b1, SMAX[DOUT_WIDTH-1:0]};
        end else if (q < SMIN) begin
            rnd_sat = {1'b1, SMIN[DOUT_WIDTH-1:0]};
        end else begin
            rnd_sat = {1'b0, q[DOUT_WIDTH-1:0]};
        end
    endfunction

    logic [DOUT_WIDTH:0]   rs_c   [4][DEPTH];
    logic [DOUT_WIDTH-1:0] dout_q [4][DEPTH];
    logic [BCW-1:0]        blk_sat_c;
    logic [SCW:0]          sum_c;

    for (genvar l = 0; l < int'(DEPTH); l++) begin : g_lane
        assign rs_c[0][l]    = rnd_sat(din_R_add[l]);
        assign rs_c[1][l]    = rnd_sat(din_Q_add[l]);
        assign rs_c[2][l]    = rnd_sat(din_R_sub[l]);
        assign rs_c[3][l]    = rnd_sat(din_Q_sub[l]);
        assign dout_R_add[l] = dout_q[0][l];
        assign dout_Q_add[l] = dout_q[1][l];
        assign dout_R_sub[l] = dout_q[2][l];
        assign dout_Q_sub[l] = dout_q[3][l];
    end

    // Saturated values in the incoming block.
    always_comb begin
        blk_sat_c = '0;
        for (int c = 0; c < 4; c++) begin
            for (int l = 0; l < int'(DEPTH); l++) begin
                blk_sat_c = blk_sat_c + BCW'(rs_c[c][l][DOUT_WIDTH]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 4; c++) begin
                for (int l = 0; l < int'(DEPTH); l++) begin
                    dout_q[c][l] <= '0;
                end
            end
        end else if (din_valid) begin
            for (int c = 0; c < 4; c++) begin
                for (int l = 0; l < int'(DEPTH); l++) begin
                    dout_q[c][l] <= rs_c[c][l][DOUT_WIDTH-1:0];
                end
            end
        end
    end

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 fs_q, fs_d;
    logic                 fd_q, fd_d;
    logic [CNT_WIDTH-1:0] idx_q, idx_d;
    logic                 flag_q, flag_d;
    logic [SCW-1:0]       scnt_q, scnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            fd_q    <= 1'b0;
            idx_q   <= '0;
            flag_q  <= 1'b0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            fs_q    <= fs_d;
            fd_q    <= fd_d;
            idx_q   <= idx_d;
            flag_q  <= flag_d;
            scnt_q  <= scnt_d;
        end
    end

    assign sum_c = {1'b0, scnt_q} + (SCW+1)'(blk_sat_c);

    // Block sequencing and per-frame saturation statistics.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        fs_d    = 1'b0;
        fd_d    = 1'b0;
        idx_d   = idx_q;
        flag_d  = flag_q;
        scnt_d  = scnt_q;
        if (din_valid) begin
            valid_d = 1'b1;
            case (state_q)
                IDLE: begin
                    fs_d  = 1'b1;
                    idx_d = '0;
                    if (FRAME_BLKS == 1) begin
                        fd_d = 1'b1;
                    end else begin
                        cnt_d   = CNT_WIDTH'(1);
                        state_d = RUN;
                    end
                end
                RUN: begin
                    idx_d = cnt_q;
                    if (cnt_q == CNT_WIDTH'(FRAME_BLKS - 1)) begin
                        fd_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
            if (fs_d) begin
                flag_d = |blk_sat_c;
                scnt_d = SCW'(blk_sat_c);
            end else begin
                flag_d = flag_q | (|blk_sat_c);
                scnt_d = sum_c[SCW] ? '1 : sum_c[SCW-1:0];
            end
        end
    end

    assign dout_valid  = valid_q;
    assign frame_start = fs_q;
    assign frame_done  = fd_q;
    assign blk_idx     = idx_q;
    assign sat_flag    = flag_q;
    assign sat_cnt     = scnt_q;

endmodule

// File: tb/tb_twf_round_sat.sv
// Directed bench for twf_round_sat: frame-level reference model checked every cycle,
// plus hand-computed literal expectations.
module tb_twf_round_sat;
    localparam int DW = 23;
    localparam int OW = 13;
    localparam int NL = 16;
    localparam int NB = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic din_valid;
    logic signed [DW-1:0] din_R_add [NL];
    logic signed [DW-1:0] din_Q_add [NL];
    logic signed [DW-1:0] din_R_sub [NL];
    logic signed [DW-1:0] din_Q_sub [NL];
    logic signed [OW-1:0] dout_R_add [NL];
    logic signed [OW-1:0] dout_Q_add [NL];
    logic signed [OW-1:0] dout_R_sub [NL];
    logic signed [OW-1:0] dout_Q_sub [NL];
    logic       dout_valid, frame_start, frame_done, sat_flag;
    logic [4:0] blk_idx;
    logic [8:0] sat_cnt;

    int n_checks = 0;
    int n_errors = 0;

    twf_round_sat dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid),
        .din_R_add(din_R_add), .din_Q_add(din_Q_add),
        .din_R_sub(din_R_sub), .din_Q_sub(din_Q_sub),
        .dout_R_add(dout_R_add), .dout_Q_add(dout_Q_add),
        .dout_R_sub(dout_R_sub), .dout_Q_sub(dout_Q_sub),
        .dout_valid(dout_valid), .frame_start(frame_start), .frame_done(frame_done),
        .blk_idx(blk_idx), .sat_flag(sat_flag), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int get_in(input int c, input int l);
        case (c)
            0: return int'(din_R_add[l]);
            1: return int'(din_Q_add[l]);
            2: return int'(din_R_sub[l]);
            default: return int'(din_Q_sub[l]);
        endcase
    endfunction

    function automatic int get_out(input int c, input int l);
        case (c)
            0: return int'(dout_R_add[l]);
            1: return int'(dout_Q_add[l]);
            2: return int'(dout_R_sub[l]);
            default: return int'(dout_Q_sub[l]);
        endcase
    endfunction

    task automatic set_one(input int c, input int l, input int v);
        case (c)
            0: din_R_add[l] = DW'(v);
            1: din_Q_add[l] = DW'(v);
            2: din_R_sub[l] = DW'(v);
            default: din_Q_sub[l] = DW'(v);
        endcase
    endtask

    task automatic set_all(input int v);
        for (int c = 0; c < 4; c++)
            for (int l = 0; l < NL; l++) set_one(c, l, v);
    endtask

    // Deterministic spread that crosses both clamp limits and all rounding cases.
    task automatic set_pat(input int b);
        for (int c = 0; c < 4; c++)
            for (int l = 0; l < NL; l++)
                set_one(c, l, (((b * 37 + l * 11 + c * 5) % 97) - 48) * 12000 + ((l * 13) % 128));
    endtask

    // Reference: value/128 rounded to nearest, ties per selected mode, then clamped.
    function automatic int m_round(input int x, output bit sat);
        int fl, r;
        fl = x >>> 7;
        r  = x - fl * 128;
`ifdef TWF_RND_CONV_EN
        if (r > 64 || (r == 64 && (fl & 1) != 0)) fl++;
`else
        if (r >= 64) fl++;
`endif
        sat = 1'b0;
        if (fl > 4095) begin fl = 4095; sat = 1'b1; end
        if (fl < -4096) begin fl = -4096; sat = 1'b1; end
        return fl;
    endfunction

    int e_out [4][NL];
    bit e_valid, e_fs, e_fd, e_flag;
    int e_idx, e_cnt;
    int m_pos;

    // Model update on each edge, DUT compared 1 time unit later.
    always begin
        @(posedge clk);
        if (!rst_n) begin
            for (int c = 0; c < 4; c++)
                for (int l = 0; l < NL; l++) e_out[c][l] = 0;
            e_valid = 0; e_fs = 0; e_fd = 0; e_flag = 0; e_idx = 0; e_cnt = 0; m_pos = 0;
        end else if (din_valid) begin
            int k;
            bit s;
            k = 0;
            for (int c = 0; c < 4; c++)
                for (int l = 0; l < NL; l++) begin
                    e_out[c][l] = m_round(get_in(c, l), s);
                    if (s) k++;
                end
            e_valid = 1;
            e_fs    = (m_pos == 0);
            e_fd    = (m_pos == NB - 1);
            e_idx   = m_pos;
            m_pos   = (m_pos + 1) % NB;
            if (e_fs) begin
                e_flag = (k > 0);
                e_cnt  = k;
            end else begin
                e_flag = e_flag || (k > 0);
                e_cnt  = (e_cnt + k > 511) ? 511 : e_cnt + k;
            end
        end else begin
            e_valid = 0; e_fs = 0; e_fd = 0;
        end
        #1;
        begin
            int bad, fc, fl, fa;
            bad = 0; fc = 0; fl = 0; fa = 0;
            for (int c = 0; c < 4; c++)
                for (int l = 0; l < NL; l++)
                    if (get_out(c, l) != e_out[c][l]) begin
                        if (bad == 0) begin fc = c; fl = l; fa = get_out(c, l); end
                        bad++;
                    end
            n_checks++;
            if (bad != 0) begin
                n_errors++;
                $display("FAIL data: %0d lanes differ, comp %0d lane %0d got %0d expected %0d at %0t",
                         bad, fc, fl, fa, e_out[fc][fl], $time);
            end
        end
        chk("dout_valid", int'(dout_valid), int'(e_valid));
        chk("frame_start", int'(frame_start), int'(e_fs));
        chk("frame_done", int'(frame_done), int'(e_fd));
        chk("blk_idx", int'(blk_idx), e_idx);
        chk("sat_flag", int'(sat_flag), int'(e_flag));
        chk("sat_cnt", int'(sat_cnt), e_cnt);
    end

    task automatic blk();
        din_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        din_valid = 1'b0;
        set_all(0);
        repeat (2) @(negedge clk);
        chk("rst dout_valid", int'(dout_valid), 0);
        chk("rst sat_cnt", int'(sat_cnt), 0);
        chk("rst blk_idx", int'(blk_idx), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Rounding.
        set_all(8192);  blk();
        chk("unity valid", int'(dout_valid), 1);
        chk("unity R_add0", int'(dout_R_add[0]), 64);
        chk("unity Q_sub15", int'(dout_Q_sub[15]), 64);
        set_all(8256);  blk();
`ifdef TWF_RND_CONV_EN
        chk("tie even", int'(dout_Q_add[3]), 64);
`else
        chk("tie up", int'(dout_Q_add[3]), 65);
`endif
        set_all(8384);  blk();
        chk("tie odd", int'(dout_R_sub[7]), 66);
        set_all(-8384); blk();
`ifdef TWF_RND_CONV_EN
        chk("neg tie", int'(dout_R_add[9]), -66);
`else
        chk("neg tie", int'(dout_R_add[9]), -65);
`endif
        idle(1);
        chk("valid drop", int'(dout_valid), 0);
        chk("hold data", int'(dout_R_add[9]), int'(dout_Q_sub[0]));

        // Saturation in a single block.
        do_reset();
        set_all(0);
        set_one(0, 0, 524288);
        set_one(3, 1, -524416);
        blk();
        chk("sat hi", int'(dout_R_add[0]), 4095);
        chk("sat lo", int'(dout_Q_sub[1]), -4096);
        chk("sat flag", int'(sat_flag), 1);
        chk("sat cnt", int'(sat_cnt), 2);
        idle(1);

        // Full frame with gaps after blocks 5 and 20.
        do_reset();
        for (int b = 0; b < NB; b++) begin
            set_pat(b);
            blk();
            chk("ff idx", int'(blk_idx), b);
            chk("ff start", int'(frame_start), (b == 0) ? 1 : 0);
            chk("ff done", int'(frame_done), (b == NB - 1) ? 1 : 0);
            if (b == 5 || b == 20) begin
                idle(3);
                chk("gap valid", int'(dout_valid), 0);
                chk("gap idx", int'(blk_idx), b);
            end
        end
        idle(2);

        // Back-to-back frames; stats restart on the new frame.
        do_reset();
        for (int b = 0; b < NB; b++) begin
            set_all(0);
            if (b == NB - 1)
                for (int l = 0; l < 5; l++) set_one(0, l, 600000);
            blk();
        end
        chk("f1 done", int'(frame_done), 1);
        chk("f1 cnt", int'(sat_cnt), 5);
        set_all(0);
        blk();
        chk("f2 start", int'(frame_start), 1);
        chk("f2 idx", int'(blk_idx), 0);
        chk("f2 cnt", int'(sat_cnt), 0);
        chk("f2 flag", int'(sat_flag), 0);
        idle(1);

        // Reset asserted while block 12 is presented.
        do_reset();
        for (int b = 0; b < 12; b++) begin
            set_pat(b);
            blk();
        end
        set_pat(12);
        din_valid = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("mid rst valid", int'(dout_valid), 0);
        chk("mid rst idx", int'(blk_idx), 0);
        chk("mid rst cnt", int'(sat_cnt), 0);
        chk("mid rst data", int'(dout_R_add[0]), 0);
        rst_n = 1'b1;
        idle(1);
        set_all(8192);
        blk();
        chk("post rst start", int'(frame_start), 1);
        chk("post rst idx", int'(blk_idx), 0);
        idle(1);

        // sat_cnt clamp at 511.
        do_reset();
        set_all(600000);
        for (int i = 0; i < 9; i++) begin
            blk();
            chk("clamp cnt", int'(sat_cnt), (64 * (i + 1) > 511) ? 511 : 64 * (i + 1));
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
